dac_share_arbiter: RTL and testbench

- Shares the single SPI DAC path (spi2dac serialiser plus its load strobe) between two sample sources, e.g. the ROM sine generator and a test/ramp source.
- Accepts samples through a valid/ready handshake and picks a source round-robin.
- Latches the chosen sample, issues a one-cycle load pulse to spi2dac, then holds off further loads until the serial transfer has finished.
- Sits between the sample generators and spi2dac/pwm in the top level.

---
 rtl/dac_share_arbiter.sv | 114 +++++++++++
 tb/tb_dac_share_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dac_share_arbiter.sv
// Two-source round-robin arbiter feeding one spi2dac/pwm path with a hold-off per transfer.
// Define DAC_ARB_FIXED_PRIO_EN to make source 0 always win a contest instead of alternating.
module dac_share_arbiter #(
   parameter int DATA_W      = 10,
   parameter int XFER_CYCLES = 1000,
   parameter int CNT_W       = 10
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   output logic [1:0]        req_ready,
   output logic [DATA_W-1:0] dac_data,
   output logic              dac_load,
   output logic              grant_id,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      BUSY = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              grant_q, grant_d;
   logic              load_q;
   logic              busy_q;
   logic              winner_s;

   // Contest winner among the currently valid sources
   always_comb begin
      winner_s = 1'b0;
      case (req_valid)
         2'b01:   winner_s = 1'b0;
         2'b10:   winner_s = 1'b1;
         2'b11: begin
`ifdef DAC_ARB_FIXED_PRIO_EN
            winner_s = 1'b0;
`else
            winner_s = ~last_grant_q;
`endif
         end
         default: winner_s = 1'b0;
      endcase
   end

   // Next-state, handshake and counter control
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      data_d       = data_q;
      grant_d      = grant_q;
      req_ready    = 2'b00;
      case (state_q)
         IDLE: begin
            if (!reset && (req_valid != 2'b00)) begin
               req_ready    = winner_s ? 2'b10 : 2'b01;
               data_d       = winner_s ? req_data1 : req_data0;
               grant_d      = winner_s;
               last_grant_d = winner_s;
               state_d      = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            cnt_d   = CNT_W'(XFER_CYCLES - 1);
            state_d = BUSY;
         end
         BUSY: begin
            // Counter is only reloaded in LOAD and halts at zero, so it never wraps
            if (cnt_q == {CNT_W{1'b0}}) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any transfer in flight
   always_ff @(posedge sysclk) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= {CNT_W{1'b0}};
         last_grant_q <= 1'b1;
         data_q       <= {DATA_W{1'b0}};
         grant_q      <= 1'b0;
         load_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         grant_q      <= grant_d;
         load_q       <= (state_d == LOAD);
         busy_q       <= (state_d != IDLE);
      end
   end

   assign dac_data = data_q;
   assign dac_load = load_q;
   assign grant_id = grant_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Randomized self-checking bench for dac_share_arbiter against a cycle-age reference model.
module tb_dac_share_arbiter;

   localparam int XFER     = 13;
   localparam int IDLE_AGE = XFER + 2;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [9:0] req_data0 = 10'd0;
   logic [9:0] req_data1 = 10'd0;
   logic [1:0] req_ready;
   logic [9:0] dac_data;
   logic       dac_load;
   logic       grant_id;
   logic       busy;

   int n_total = 0;
   int n_bad   = 0;

   // Model: age = cycles since the last accept edge; IDLE_AGE means idle/never accepted.
   int         age      = IDLE_AGE;
   logic       exp_last = 1'b1;
   logic       exp_gid  = 1'b0;
   logic [9:0] exp_data = 10'd0;
   logic [1:0] exp_ready;

   dac_share_arbiter #(
      .DATA_W(10),
      .XFER_CYCLES(XFER),
      .CNT_W(10)
   ) dut (
      .sysclk(sysclk),
      .reset(reset),
      .req_valid(req_valid),
      .req_data0(req_data0),
      .req_data1(req_data1),
      .req_ready(req_ready),
      .dac_data(dac_data),
      .dac_load(dac_load),
      .grant_id(grant_id),
      .busy(busy)
   );

   always #5 sysclk = ~sysclk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got=0x%0h expected=0x%0h", tag, $time, got, exp);
      end
   endtask

   task automatic run_cycle(input logic rst, input logic [1:0] v,
                            input logic [9:0] d0, input logic [9:0] d1);
      logic g;
      g = 1'b0;
      @(negedge sysclk);
      reset     = rst;
      req_valid = v;
      req_data0 = d0;
      req_data1 = d1;
      #1;
      exp_ready = 2'b00;
      if (!rst && age >= IDLE_AGE && v != 2'b00) begin
         if (v == 2'b11) begin
`ifdef DAC_ARB_FIXED_PRIO_EN
            g = 1'b0;
`else
            g = ~exp_last;
`endif
         end else begin
            g = v[1];
         end
         exp_ready = g ? 2'b10 : 2'b01;
      end
      check_val("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
      @(posedge sysclk);
      #1;
      if (rst) begin
         age      = IDLE_AGE;
         exp_last = 1'b1;
         exp_gid  = 1'b0;
         exp_data = 10'd0;
      end else if (exp_ready != 2'b00) begin
         age      = 1;
         exp_data = g ? d1 : d0;
         exp_gid  = g;
         exp_last = g;
      end else if (age < IDLE_AGE) begin
         age++;
      end
      check_val("dac_load", {31'd0, dac_load}, {31'd0, (age == 1)});
      check_val("busy", {31'd0, busy}, {31'd0, (age >= 1 && age <= XFER + 1)});
      check_val("dac_data", {22'd0, dac_data}, {22'd0, exp_data});
      check_val("grant_id", {31'd0, grant_id}, {31'd0, exp_gid});
   endtask

   initial begin
      // Reset state
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 2'b11, 10'h3FF, 10'h3FF);
      // Single source 0 accept and full busy window
      run_cycle(1'b0, 2'b01, 10'h155, 10'h2A2);
      for (int i = 0; i < XFER + 3; i++) run_cycle(1'b0, 2'b00, 10'h000, 10'h000);
      // Both sources continuously valid: alternation and load spacing
      for (int i = 0; i < 5 * (XFER + 2); i++) run_cycle(1'b0, 2'b11, 10'h0AA, 10'h3FF);
      // Source 1 requests during busy, accepted on first idle cycle
      run_cycle(1'b0, 2'b01, 10'h123, 10'h000);
      for (int i = 0; i < XFER + 4; i++) run_cycle(1'b0, 2'b10, 10'h000, 10'h2C3);
      // Reset mid-busy, then contest must go to source 0
      run_cycle(1'b0, 2'b11, 10'h011, 10'h022);
      for (int i = 0; i < XFER / 2; i++) run_cycle(1'b0, 2'b00, 10'h000, 10'h000);
      run_cycle(1'b1, 2'b00, 10'h000, 10'h000);
      for (int i = 0; i < XFER + 4; i++) run_cycle(1'b0, 2'b11, 10'h044, 10'h088);
      // Randomized traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         run_cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
                   2'($urandom_range(0, 3)),
                   10'($urandom), 10'($urandom));
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
